// File: rtl/clock_mode_controller_if.sv
// Signal bundle between the clock sequencer and the six digit modules / button front end.
interface clock_mode_controller_if;
    logic        btnStart;
    logic        btnSet;
    logic        btnNext;
    logic        btnInc;
    logic [23:0] digitValues;
    logic [3:0]  state;
    logic [5:0]  tick;
    logic [23:0] setBus;
    logic [23:0] maxBits;
    logic [2:0]  setDigit;

    modport master (
        input  btnStart, btnSet, btnNext, btnInc, digitValues,
        output state, tick, setBus, maxBits, setDigit
    );

    modport slave (
        output btnStart, btnSet, btnNext, btnInc, digitValues,
        input  state, tick, setBus, maxBits, setDigit
    );
endinterface

// File: rtl/clock_mode_controller.sv
// Top-level sequencer for the six-digit 24-hour clock: mode FSM, one-second prescaler,
// carry-chain advance pulses, per-digit maximums and the set-mode shadow registers.
module clock_mode_controller #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    clock_mode_controller_if.master bus
);
    localparam int unsigned DIGITS = 6;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BTN_W  = 4;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]       MODE_RESET = 4'd0;
    localparam logic [3:0]       MODE_SET   = 4'd1;
    localparam logic [3:0]       MODE_START = 4'd3;

    typedef enum logic [2:0] {
        S_RESET,
        S_SET,
        S_RUN,
        S_PAUSE,
        S_CLR
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_next;
    logic [3:0]       r_state;
    logic [3:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_tick0;
    logic             w_tick0_next;
    logic [2:0]       r_set_digit;
    logic [2:0]       w_set_digit_next;
    logic [NIB_W-1:0] r_shadow      [DIGITS];
    logic [NIB_W-1:0] w_shadow_next [DIGITS];
    logic [NIB_W-1:0] w_max         [DIGITS];
    logic [NIB_W-1:0] w_hhb;

    logic [BTN_W-1:0] r_btn_prev;
    logic [BTN_W-1:0] w_btn;
    logic [BTN_W-1:0] w_rise;
    logic             w_go_start;
    logic             w_go_set;
    logic             w_go_next;
    logic             w_go_inc;

    logic [DIGITS-1:0] w_tick;
    logic              w_chain;

    // Rising-edge detect with Start > Set > Next > Inc priority; losers are dropped.
    assign w_btn      = {bus.btnInc, bus.btnNext, bus.btnSet, bus.btnStart};
    assign w_rise     = w_btn & ~r_btn_prev;
    assign w_go_start = w_rise[0];
    assign w_go_set   = w_rise[1] & ~w_rise[0];
    assign w_go_next  = w_rise[2] & ~(|w_rise[1:0]);
    assign w_go_inc   = w_rise[3] & ~(|w_rise[2:0]);

    // Hours-units limit follows the live digits while counting, the shadow while editing.
    always_comb begin
        w_hhb = ((r_fsm == S_RUN) || (r_fsm == S_PAUSE)) ? bus.digitValues[23:20] : r_shadow[5];
        w_max[0] = 4'd9;
        w_max[1] = 4'd5;
        w_max[2] = 4'd9;
        w_max[3] = 4'd5;
        w_max[4] = (w_hhb == 4'd2) ? 4'd3 : 4'd9;
        w_max[5] = 4'd2;
    end

    // Next-state, prescaler and shadow-edit logic.
    always_comb begin
        w_fsm_next       = r_fsm;
        w_cnt_next       = r_cnt;
        w_set_digit_next = r_set_digit;
        for (int i = 0; i < DIGITS; i++) begin
            w_shadow_next[i] = r_shadow[i];
        end

        case (r_fsm)
            S_RESET: begin
                if (w_go_start) begin
                    w_fsm_next = S_RUN;
                    w_cnt_next = '0;
                end else if (w_go_set) begin
                    w_fsm_next = S_SET;
                end
            end
            S_SET: begin
                if (w_go_start) begin
                    w_fsm_next = S_RUN;
                    w_cnt_next = '0;
                end else if (w_go_next) begin
                    w_set_digit_next = (r_set_digit == 3'd5) ? 3'd0 : r_set_digit + 3'd1;
                end else if (w_go_inc) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_set_digit == 3'(i)) begin
                            w_shadow_next[i] = (r_shadow[i] == w_max[i]) ? '0 : r_shadow[i] + 4'd1;
                        end
                    end
                    // Moving the tens-of-hours to 2 must not leave an illegal 24..29.
                    if ((r_set_digit == 3'd5) && (w_shadow_next[5] == 4'd2) && (r_shadow[4] > 4'd3)) begin
                        w_shadow_next[4] = '0;
                    end
                end
            end
            S_RUN: begin
                if (w_go_start) begin
                    w_fsm_next = S_PAUSE;
                end else begin
                    w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
                end
            end
            S_PAUSE: begin
                if (w_go_start) begin
                    w_fsm_next = S_RUN;
                end else if (w_go_set) begin
                    w_fsm_next = S_CLR;
                    for (int i = 0; i < DIGITS; i++) begin
                        w_shadow_next[i] = bus.digitValues[NIB_W*i +: NIB_W];
                    end
                end
            end
            S_CLR: begin
                w_fsm_next = S_SET;
            end
            default: begin
                w_fsm_next = S_RESET;
            end
        endcase

        w_tick0_next = (w_fsm_next == S_RUN) && (w_cnt_next == CNT_LAST);

        case (w_fsm_next)
            S_SET:          w_state_next = MODE_SET;
            S_RUN, S_PAUSE: w_state_next = MODE_START;
            default:        w_state_next = MODE_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm       <= S_RESET;
            r_state     <= MODE_RESET;
            r_cnt       <= '0;
            r_tick0     <= 1'b0;
            r_set_digit <= '0;
            r_btn_prev  <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_fsm       <= w_fsm_next;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_tick0     <= w_tick0_next;
            r_set_digit <= w_set_digit_next;
            r_btn_prev  <= w_btn;
            for (int i = 0; i < DIGITS; i++) begin
                r_shadow[i] <= w_shadow_next[i];
            end
        end
    end

    // Carry chain: a digit advances when every lower digit is at its maximum.
    always_comb begin
        w_chain = r_tick0;
        for (int i = 0; i < DIGITS; i++) begin
            w_tick[i] = w_chain;
            w_chain   = w_chain & (bus.digitValues[NIB_W*i +: NIB_W] == w_max[i]);
        end
    end

    assign bus.state    = r_state;
    assign bus.tick     = w_tick;
    assign bus.setDigit = r_set_digit;
    assign bus.setBus   = {r_shadow[5], r_shadow[4], r_shadow[3], r_shadow[2], r_shadow[1], r_shadow[0]};
    assign bus.maxBits  = {w_max[5], w_max[4], w_max[3], w_max[2], w_max[1], w_max[0]};
endmodule

// File: tb/tb_clock_mode_controller.sv
// Scoreboard bench for clock_mode_controller: driver queues expectations, monitor checks them.
module tb_clock_mode_controller;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned CNT_W    = 3;

    localparam int F_STATE  = 0;
    localparam int F_TICK   = 1;
    localparam int F_SETBUS = 2;
    localparam int F_MAX    = 3;
    localparam int F_DIGIT  = 4;

    localparam int B_START = 0;
    localparam int B_SET   = 1;
    localparam int B_NEXT  = 2;
    localparam int B_INC   = 3;

    typedef struct {
        int          slot;
        int          field;
        logic [23:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    clock_mode_controller_if ifc ();

    clock_mode_controller #(
        .TICK_DIV(TICK_DIV),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] actual(input int f);
        case (f)
            F_STATE:  return {20'd0, ifc.state};
            F_TICK:   return {18'd0, ifc.tick};
            F_SETBUS: return ifc.setBus;
            F_MAX:    return ifc.maxBits;
            default:  return {21'd0, ifc.setDigit};
        endcase
    endfunction

    // Slot 2*cycle+0 is 1 time unit after posedge, slot 2*cycle+1 is the negedge.
    task automatic check_slot(input int s);
        exp_t        e;
        logic [23:0] a;
        while (sb.size() > 0 && sb[0].slot <= s) begin
            e = sb.pop_front();
            a = actual(e.field);
            n_vec++;
            if (e.slot != s || a !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h (slot %0d, checked at %0d)",
                         e.name, a, e.val, e.slot, s);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check_slot(2 * cyc);
            @(negedge clk);
            check_slot(2 * cyc + 1);
        end
    end

    task automatic push(input int k, input int half, input int f, input logic [23:0] v, input string nm);
        exp_t e;
        e.slot  = 2 * (cyc + k) + half;
        e.field = f;
        e.val   = v;
        e.name  = nm;
        sb.push_back(e);
    endtask

    task automatic expb(input int f, input logic [23:0] v, input string nm);
        push(0, 1, f, v, nm);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_START: ifc.btnStart = v;
            B_SET:   ifc.btnSet   = v;
            B_NEXT:  ifc.btnNext  = v;
            default: ifc.btnInc   = v;
        endcase
    endtask

    // Returns in the first cycle that shows the button's effect.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        step();
        set_btn(b, 1'b0);
    endtask

    task automatic tap(input int b);
        press(b);
        step();
    endtask

    initial begin
        logic [23:0] t;
        rst             = 1'b1;
        ifc.btnStart    = 1'b0;
        ifc.btnSet      = 1'b0;
        ifc.btnNext     = 1'b0;
        ifc.btnInc      = 1'b0;
        ifc.digitValues = 24'h000000;
        step();
        step();
        expb(F_STATE,  24'h000000, "rst_state");
        expb(F_TICK,   24'h000000, "rst_tick");
        expb(F_SETBUS, 24'h000000, "rst_setbus");
        expb(F_DIGIT,  24'h000000, "rst_digit");
        expb(F_MAX,    24'h295959, "rst_max");
        step();
        rst = 1'b0;
        step();

        // Set edits
        tap(B_SET);
        tap(B_NEXT);
        tap(B_NEXT);
        for (int i = 0; i < 3; i++) tap(B_INC);
        expb(F_STATE,  24'h000001, "set_state");
        expb(F_DIGIT,  24'h000002, "set_digit2");
        expb(F_SETBUS, 24'h000300, "set_bus_300");
        for (int i = 0; i < 4; i++) tap(B_NEXT);
        expb(F_DIGIT, 24'h000000, "digit_wrap");
        for (int i = 0; i < 9; i++) tap(B_INC);
        expb(F_SETBUS, 24'h000309, "lsb_at_9");
        tap(B_INC);
        expb(F_SETBUS, 24'h000300, "lsb_wrap");

        // Clamp: HHB 1->2 while HLB = 7
        for (int i = 0; i < 4; i++) tap(B_NEXT);
        for (int i = 0; i < 7; i++) tap(B_INC);
        tap(B_NEXT);
        tap(B_INC);
        expb(F_SETBUS, 24'h170300, "pre_clamp");
        expb(F_MAX,    24'h295959, "max_hhb1");
        tap(B_INC);
        expb(F_SETBUS, 24'h200300, "clamp");
        expb(F_MAX,    24'h235959, "max_hhb2");
        expb(F_DIGIT,  24'h000005, "digit5");

        // Start + Inc together: Start wins
        ifc.btnStart = 1'b1;
        ifc.btnInc   = 1'b1;
        step();
        ifc.btnStart = 1'b0;
        ifc.btnInc   = 1'b0;
        expb(F_STATE,  24'h000003, "prio_run");
        expb(F_SETBUS, 24'h200300, "prio_shadow");
        expb(F_MAX,    24'h295959, "run_max_live");

        // Tick cadence and rollover carries
        for (int r = 1; r <= 16; r++) begin
            if (r == 9)  ifc.digitValues = 24'h235959;
            if (r == 13) ifc.digitValues = 24'h195959;
            t = 24'h000000;
            if (r % 4 == 0) t = (r <= 8) ? 24'h000001 : 24'h00003f;
            expb(F_TICK, t, $sformatf("tick_r%0d", r));
            if (r == 12) expb(F_MAX, 24'h235959, "roll23_max");
            if (r == 16) expb(F_MAX, 24'h295959, "roll19_max");
            step();
        end

        // Pause: no ticks
        ifc.digitValues = 24'h000000;
        press(B_START);
        for (int i = 0; i < 20; i++) begin
            expb(F_STATE, 24'h000003, "pause_state");
            expb(F_TICK,  24'h000000, "pause_tick");
            step();
        end

        // Pause -> CLR -> SET capturing the live time
        ifc.digitValues = 24'h124530;
        press(B_SET);
        expb(F_STATE,  24'h000000, "clr_state");
        expb(F_SETBUS, 24'h124530, "clr_capture");
        expb(F_MAX,    24'h295959, "clr_max");
        push(1, 1, F_STATE, 24'h000001, "clr_to_set");
        step();
        press(B_START);
        expb(F_STATE, 24'h000003, "edit_run");
        expb(F_TICK,  24'h000000, "edit_r1");
        step();
        expb(F_TICK, 24'h000000, "edit_r2");
        step();
        expb(F_TICK, 24'h000000, "edit_r3");
        press(B_START);
        expb(F_STATE, 24'h000003, "pause2_state");
        expb(F_TICK,  24'h000000, "pause2_tick");
        step();
        step();
        press(B_START);
        expb(F_TICK, 24'h000000, "resume_q1");
        push(1, 0, F_TICK, 24'h000001, "resume_tick");
        step();

        // Reset mid-RUN with tick high, checked before the next edge
        rst = 1'b1;
        expb(F_STATE,  24'h000000, "arst_state");
        expb(F_TICK,   24'h000000, "arst_tick");
        expb(F_SETBUS, 24'h000000, "arst_setbus");
        expb(F_DIGIT,  24'h000000, "arst_digit");
        step();
        rst = 1'b0;
        ifc.digitValues = 24'h000000;
        step();

        // Tick timing from RESET
        press(B_START);
        expb(F_STATE, 24'h000003, "rst_run_state");
        for (int r = 1; r <= 12; r++) begin
            t = (r % 4 == 0) ? 24'h000001 : 24'h000000;
            expb(F_TICK, t, $sformatf("t0_r%0d", r));
            step();
        end

        step();
        step();
        if (sb.size() != 0) begin
            n_bad += sb.size();
            $display("FAIL drain: got %0d unchecked expectations, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
